// File: rtl/exp7_detector_jogada.sv
// Player-move detector for the board push-buttons.
//
// The four raw buttons pass through a two-flop synchronizer. The result is
// debounced and screened for multi-button presses. Each accepted press
// produces exactly one single-cycle jogada_feita pulse. Before a new press
// can be accepted, all buttons must be released and stay stable for
// DEBOUNCE_CICLOS samples.
//
// Ports:
//   clock         system clock, rising edge
//   reset         synchronous, active-high reset
//   botoes[3:0]   raw asynchronous buttons, active-high, bit i = colour i
//   habilita      control unit is currently accepting a move
//   jogada[3:0]   one-hot code of the last accepted move (held)
//   jogada_feita  one-cycle pulse: jogada is valid and new
//   db_multiplo   one-cycle pulse: stable multi-button press rejected
//   db_estado     current FSM state (debug)
module exp7_detector_jogada #(
    parameter int DEBOUNCE_CICLOS = 50000,
    parameter int CONT_W          = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] botoes,
    input  logic       habilita,
    output logic [3:0] jogada,
    output logic       jogada_feita,
    output logic       db_multiplo,
    output logic [2:0] db_estado
);

    typedef enum logic [2:0] {
        LIBERA   = 3'd0,
        OCIOSO   = 3'd1,
        FILTRA   = 3'd2,
        REGISTRA = 3'd3,
        REJEITA  = 3'd4
    } estado_t;

    localparam logic [CONT_W-1:0] CONT_FIM = CONT_W'(DEBOUNCE_CICLOS - 1);

    estado_t           estado_q, estado_d;
    logic [CONT_W-1:0] cont_q,   cont_d;
    logic [3:0]        padrao_q, padrao_d;
    logic [3:0]        jogada_q, jogada_d;
    logic [3:0]        sinc1_q;
    logic [3:0]        sinc_q;
    logic              padrao_onehot;

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    assign padrao_onehot = (padrao_q != 4'b0000) &&
                           ((padrao_q & (padrao_q - 4'd1)) == 4'b0000);

    // State register, synchronizer and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= LIBERA;
            cont_q   <= '0;
            padrao_q <= 4'b0000;
            jogada_q <= 4'b0000;
            sinc1_q  <= 4'b0000;
            sinc_q   <= 4'b0000;
        end else begin
            estado_q <= estado_d;
            cont_q   <= cont_d;
            padrao_q <= padrao_d;
            jogada_q <= jogada_d;
            sinc1_q  <= botoes;
            sinc_q   <= sinc1_q;
        end
    end

    // Next-state and datapath update
    always_comb begin
        estado_d = estado_q;
        cont_d   = cont_q;
        padrao_d = padrao_q;
        jogada_d = jogada_q;
        case (estado_q)
            LIBERA: begin
                if (sinc_q != 4'b0000) begin
                    cont_d = '0;
                end else if (cont_q == CONT_FIM) begin
                    cont_d   = '0;
                    estado_d = OCIOSO;
                end else begin
                    cont_d = cont_q + 1'b1;
                end
            end
            OCIOSO: begin
                if (sinc_q != 4'b0000) begin
                    cont_d = '0;
                    if (habilita) begin
                        padrao_d = sinc_q;
                        estado_d = FILTRA;
                    end else begin
                        // Press made while moves are not accepted: it is
                        // ignored, and the buttons must be released again.
                        estado_d = LIBERA;
                    end
                end
            end
            FILTRA: begin
                if (!habilita) begin
                    cont_d   = '0;
                    estado_d = LIBERA;
                end else if (sinc_q != padrao_q) begin
                    cont_d   = '0;
                    estado_d = OCIOSO;
                end else if (cont_q == CONT_FIM) begin
                    cont_d = '0;
                    if (padrao_onehot) begin
                        // Load the move on the entry edge so it is stable
                        // during the pulse.
                        jogada_d = padrao_q;
                        estado_d = REGISTRA;
                    end else begin
                        estado_d = REJEITA;
                    end
                end else begin
                    cont_d = cont_q + 1'b1;
                end
            end
            REGISTRA: begin
                cont_d   = '0;
                estado_d = LIBERA;
            end
            REJEITA: begin
                cont_d   = '0;
                estado_d = LIBERA;
            end
            default: begin
                cont_d   = '0;
                estado_d = LIBERA;
            end
        endcase
    end

    // Moore outputs
    always_comb begin
        jogada       = jogada_q;
        jogada_feita = (estado_q == REGISTRA);
        db_multiplo  = (estado_q == REJEITA);
        db_estado    = estado_q;
    end

endmodule

// File: tb/tb_exp7_detector_jogada.sv
// Testbench for exp7_detector_jogada. It uses DEBOUNCE_CICLOS = 4.
//
// A reference model describes the block in terms of "needs release",
// "candidate pattern" and "run length". At every clock edge where it expects
// a pulse, the model pushes an event (cycle, kind, jogada) onto a queue. A
// separate monitor pops that queue each time the DUT pulses and compares the
// two. Directed sections follow the test plan; a randomized section follows
// them.
module tb_exp7_detector_jogada;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] botoes;
    logic       habilita;
    logic [3:0] jogada;
    logic       jogada_feita;
    logic       db_multiplo;
    logic [2:0] db_estado;

    exp7_detector_jogada #(.DEBOUNCE_CICLOS(D), .CONT_W(16)) dut (
        .clock        (clk),
        .reset        (reset),
        .botoes       (botoes),
        .habilita     (habilita),
        .jogada       (jogada),
        .jogada_feita (jogada_feita),
        .db_multiplo  (db_multiplo),
        .db_estado    (db_estado)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] kind;   // {jogada_feita, db_multiplo}
        logic [3:0] jog;
    } ev_t;

    ev_t sb[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc   = 0;
    int  n_feita = 0;
    int  n_mult  = 0;
    int  last_pulse_cyc = -1;

    // Reference model state
    logic [3:0] m_s1 = 4'b0, m_sinc = 4'b0;
    logic [3:0] m_jog = 4'b0;
    logic [3:0] cand = 4'b0;     // 0 = no candidate
    bit         need_release = 1'b1;
    bit         busy = 1'b0;     // one-cycle report slot after a decision
    int         run = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model: evaluated on the same edge the DUT updates on, using pre-edge values
    initial forever begin
        @(posedge clk);
        cyc++;
        if (reset) begin
            need_release = 1'b1; busy = 1'b0; cand = 4'b0; run = 0; m_jog = 4'b0;
            m_s1 = 4'b0; m_sinc = 4'b0;
        end else begin
            if (busy) begin
                busy = 1'b0; need_release = 1'b1; run = 0;
            end else if (need_release) begin
                if (m_sinc == 4'b0) begin
                    run++;
                    if (run == D) begin need_release = 1'b0; run = 0; end
                end else run = 0;
            end else if (cand == 4'b0) begin
                if (m_sinc != 4'b0) begin
                    run = 0;
                    if (habilita) cand = m_sinc;
                    else need_release = 1'b1;
                end
            end else begin
                if (!habilita) begin
                    cand = 4'b0; need_release = 1'b1; run = 0;
                end else if (m_sinc != cand) begin
                    cand = 4'b0; run = 0;
                end else begin
                    run++;
                    if (run == D) begin
                        if ($countones(cand) == 1) begin
                            m_jog = cand;
                            sb.push_back('{cyc: cyc, kind: 2'b10, jog: cand});
                        end else begin
                            sb.push_back('{cyc: cyc, kind: 2'b01, jog: m_jog});
                        end
                        busy = 1'b1; cand = 4'b0; run = 0;
                    end
                end
            end
            m_sinc = m_s1;
            m_s1   = botoes;
        end
    end

    // Monitor: samples on the falling edge
    initial forever begin
        ev_t e;
        @(negedge clk);
        chk("jogada_hold", {28'b0, jogada}, {28'b0, m_jog});
        if (jogada_feita || db_multiplo) begin
            if (jogada_feita) begin n_feita++; last_pulse_cyc = cyc; end
            if (db_multiplo) n_mult++;
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {30'b0, jogada_feita, db_multiplo}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("pulse_kind",   {30'b0, jogada_feita, db_multiplo}, {30'b0, e.kind});
                chk("pulse_cycle",  cyc, e.cyc);
                chk("pulse_jogada", {28'b0, jogada}, {28'b0, e.jog});
            end
        end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            chk("missed_pulse", 32'd0, {30'b0, e.kind});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int seq, last_st;
    task automatic track(input int n);
        repeat (n) begin
            @(negedge clk);
            if (int'(db_estado) != last_st) begin
                seq = seq * 8 + int'(db_estado);
                last_st = int'(db_estado);
            end
        end
    endtask

    initial begin
        int p, f0, m0, k;
        logic [3:0] pat;
        reset = 1'b1; botoes = 4'b0; habilita = 1'b1;
        tick(3);
        chk("rst_estado", {29'b0, db_estado}, 32'd0);
        chk("rst_jogada", {28'b0, jogada}, 32'd0);
        chk("rst_feita",  {31'b0, jogada_feita}, 32'd0);
        chk("rst_mult",   {31'b0, db_multiplo}, 32'd0);
        reset = 1'b0;

        // 1: clean press, latency and state walk
        seq = 1; last_st = -1;
        track(10);
        botoes = 4'b0100; p = cyc; f0 = n_feita;
        track(12);
        chk("t1_walk", seq, 32'o101230);
        chk("t1_count", n_feita - f0, 1);
        chk("t1_latency", last_pulse_cyc, p + 7);
        chk("t1_jogada", {28'b0, jogada}, 32'h4);
        botoes = 4'b0; tick(8);

        // 2: bouncing press
        f0 = n_feita;
        botoes = 4'b0001; tick(2); botoes = 4'b0; tick(1);
        botoes = 4'b0001; tick(2); botoes = 4'b0; tick(1);
        botoes = 4'b0001; tick(14);
        chk("t2_count", n_feita - f0, 1);
        chk("t2_jogada", {28'b0, jogada}, 32'h1);
        botoes = 4'b0; tick(8);

        // 3: multi-button press rejected
        f0 = n_feita; m0 = n_mult;
        botoes = 4'b0011; tick(12);
        chk("t3_mult", n_mult - m0, 1);
        chk("t3_feita", n_feita - f0, 0);
        chk("t3_jogada", {28'b0, jogada}, 32'h1);
        botoes = 4'b0; tick(8);

        // 4: press while disabled is ignored until released
        f0 = n_feita;
        habilita = 1'b0; botoes = 4'b1000; tick(6);
        habilita = 1'b1; tick(8);
        chk("t4_ignored", n_feita - f0, 0);
        botoes = 4'b0; tick(8);
        botoes = 4'b1000; tick(12);
        chk("t4_count", n_feita - f0, 1);
        chk("t4_jogada", {28'b0, jogada}, 32'h8);
        botoes = 4'b0; tick(8);

        // 5: long hold, then short release
        f0 = n_feita;
        botoes = 4'b0010; tick(100);
        chk("t5_hold", n_feita - f0, 1);
        botoes = 4'b0; tick(2);
        botoes = 4'b0100; tick(20);
        chk("t5_short_rel", n_feita - f0, 1);
        botoes = 4'b0; tick(8);
        botoes = 4'b0100; tick(12);
        chk("t5_after_rel", n_feita - f0, 2);
        botoes = 4'b0; tick(8);

        // 6: reset in the middle of filtering
        f0 = n_feita;
        botoes = 4'b0001;
        k = 0;
        while (db_estado != 3'd2 && k < 20) begin tick(1); k++; end
        chk("t6_reach_filtra", {29'b0, db_estado}, 32'd2);
        reset = 1'b1; tick(1); reset = 1'b0;
        chk("t6_estado", {29'b0, db_estado}, 32'd0);
        chk("t6_jogada", {28'b0, jogada}, 32'd0);
        chk("t6_feita",  {31'b0, jogada_feita}, 32'd0);
        tick(12);
        chk("t6_held", n_feita - f0, 0);
        botoes = 4'b0; tick(8);
        botoes = 4'b0001; tick(12);
        chk("t6_after", n_feita - f0, 1);
        botoes = 4'b0; tick(8);

        // Randomized presses, bounces, enables and occasional resets
        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 99);
            if (k < 70) pat = 4'b0001 << $urandom_range(0, 3);
            else begin
                pat = 4'($urandom_range(0, 15));
                while ($countones(pat) < 2) pat = 4'($urandom_range(0, 15));
            end
            habilita = ($urandom_range(0, 99) < 85);
            for (int c = $urandom_range(1, 10); c > 0; c--) begin
                botoes = ($urandom_range(0, 9) == 0) ? 4'b0 : pat;
                if ($urandom_range(0, 19) == 0) habilita = ~habilita;
                reset = ($urandom_range(0, 99) < 2);
                tick(1);
            end
            reset = 1'b0;
            botoes = 4'b0;
            tick($urandom_range(1, 8));
        end

        botoes = 4'b0; habilita = 1'b1; tick(12);
        chk("drain_queue", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
